// File: rtl/assist_seq.sv
// assist_seq: sequential target-current calculator for pedal assist.
// One 15x15->30 unsigned multiplier is shared over three product steps
// (torque*scale, incline*cadence, product of both), then the result is
// saturated to 12 bits and written to target_curr.
// Optional feature macro: ASSIST_SEQ_RATE_LIMIT_EN limits each increase
// of target_curr to 12'h100 per computation; decreases are unlimited.
module assist_seq (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic        [11:0] avg_torque,
    input  logic        [4:0]  cadence,
    input  logic               not_pedaling,
    input  logic signed [12:0] incline,
    input  logic        [2:0]  scale,
    output logic               busy,
    output logic               done,
    output logic        [11:0] target_curr
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MUL_TQ = 3'd1,
        MUL_IC = 3'd2,
        MUL_AP = 3'd3,
        WR     = 3'd4
    } state_t;

    state_t state_r;
    state_t state_next_s;

    // Operands captured when a computation is accepted
    logic        [11:0] torque_r;
    logic        [4:0]  cadence_r;
    logic               np_r;
    logic signed [12:0] incline_r;
    logic        [2:0]  scale_r;

    logic [14:0] prod_a_r;
    logic [14:0] prod_b_r;
    logic [29:0] prod_r;
    logic [11:0] target_r;
    logic        done_r;

    logic        [11:0] torque_pos_s;
    logic signed [9:0]  incline_sat_s;
    logic signed [10:0] incline_sum_s;
    logic        [8:0]  incline_lim_s;
    logic        [5:0]  cadence_factor_s;
    logic        [14:0] mul_a_s;
    logic        [14:0] mul_b_s;
    logic        [29:0] mul_p_s;
    logic        [11:0] result_s;
    logic        [11:0] next_target_s;

    // Operand conditioning from the captured inputs
    always_comb begin
        torque_pos_s     = 12'h000;
        incline_sat_s    = 10'sd0;
        incline_sum_s    = 11'sd0;
        incline_lim_s    = 9'd0;
        cadence_factor_s = 6'd0;

        if (torque_r > 12'h380) begin
            torque_pos_s = torque_r - 12'h380;
        end else begin
            torque_pos_s = 12'h000;
        end

        if (incline_r > 13'sd511) begin
            incline_sat_s = 10'sd511;
        end else if (incline_r < -13'sd512) begin
            incline_sat_s = -10'sd512;
        end else begin
            incline_sat_s = incline_r[9:0];
        end

        // One extra bit so -512+256 and 511+256 are both representable
        incline_sum_s = {incline_sat_s[9], incline_sat_s} + 11'sd256;

        if (incline_sum_s < 11'sd0) begin
            incline_lim_s = 9'd0;
        end else if (incline_sum_s > 11'sd511) begin
            incline_lim_s = 9'd511;
        end else begin
            incline_lim_s = incline_sum_s[8:0];
        end

        if (cadence_r > 5'd1) begin
            cadence_factor_s = {1'b0, cadence_r} + 6'd32;
        end else begin
            cadence_factor_s = 6'd0;
        end
    end

    // Operand select for the single shared multiplier
    always_comb begin
        mul_a_s = 15'd0;
        mul_b_s = 15'd0;
        case (state_r)
            MUL_TQ: begin
                mul_a_s = {3'b000, torque_pos_s};
                mul_b_s = {12'h000, scale_r};
            end
            MUL_IC: begin
                mul_a_s = {6'b000000, incline_lim_s};
                mul_b_s = {9'b000000000, cadence_factor_s};
            end
            MUL_AP: begin
                mul_a_s = prod_a_r;
                mul_b_s = prod_b_r;
            end
            default: begin
                mul_a_s = 15'd0;
                mul_b_s = 15'd0;
            end
        endcase
    end

    assign mul_p_s = {15'd0, mul_a_s} * {15'd0, mul_b_s};

    // Saturate the final product to 12 bits and apply optional rate limit
    always_comb begin
        result_s      = 12'h000;
        next_target_s = 12'h000;

        if (|prod_r[29:27]) begin
            result_s = 12'hFFF;
        end else begin
            result_s = prod_r[26:15];
        end

`ifdef ASSIST_SEQ_RATE_LIMIT_EN
        // 13-bit compare: when target_r+0x100 exceeds 0xFFF the result can
        // never be larger, so the limited path never wraps
        if ({1'b0, result_s} > ({1'b0, target_r} + 13'h0100)) begin
            next_target_s = target_r + 12'h100;
        end else begin
            next_target_s = result_s;
        end
`else
        next_target_s = result_s;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: fixed four-step sequence, start only seen in IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = MUL_TQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MUL_TQ:  state_next_s = MUL_IC;
            MUL_IC:  state_next_s = MUL_AP;
            MUL_AP:  state_next_s = WR;
            WR:      state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath registers: operand capture, products, output write
    always_ff @(posedge clk) begin
        if (rst) begin
            torque_r  <= 12'h000;
            cadence_r <= 5'd0;
            np_r      <= 1'b0;
            incline_r <= 13'sd0;
            scale_r   <= 3'd0;
            prod_a_r  <= 15'd0;
            prod_b_r  <= 15'd0;
            prod_r    <= 30'd0;
            target_r  <= 12'h000;
            done_r    <= 1'b0;
        end else begin
            done_r <= (state_r == WR);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        torque_r  <= avg_torque;
                        cadence_r <= cadence;
                        np_r      <= not_pedaling;
                        incline_r <= incline;
                        scale_r   <= scale;
                    end
                end
                MUL_TQ: prod_a_r <= mul_p_s[14:0];
                MUL_IC: prod_b_r <= mul_p_s[14:0];
                MUL_AP: begin
                    if (np_r) begin
                        prod_r <= 30'd0;
                    end else begin
                        prod_r <= mul_p_s;
                    end
                end
                WR:      target_r <= next_target_s;
                default: target_r <= target_r;
            endcase
        end
    end

    assign busy        = (state_r != IDLE);
    assign done        = done_r;
    assign target_curr = target_r;

endmodule

// File: tb/tb_assist_seq.sv
// Self-checking bench for assist_seq: directed spec cases plus randomized
// runs against a plain-arithmetic reference model.
module tb_assist_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] avg_torque;
    logic [4:0]  cadence;
    logic        not_pedaling;
    logic [12:0] incline;
    logic [2:0]  scale;
    logic        busy;
    logic        done;
    logic [11:0] target_curr;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_target;

    typedef struct packed {
        logic [11:0] tq;
        logic [4:0]  cad;
        logic        np;
        logic [12:0] inc;
        logic [2:0]  sc;
    } op_t;

    assist_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .avg_torque   (avg_torque),
        .cadence      (cadence),
        .not_pedaling (not_pedaling),
        .incline      ($signed(incline)),
        .scale        (scale),
        .busy         (busy),
        .done         (done),
        .target_curr  (target_curr)
    );

    always #5 clk = ~clk;

    // Reference: target current from the arithmetic rules, unlimited
    function automatic logic [11:0] model_result(input op_t o);
        longint tp, inc, lim, cf, p;
        tp = (o.tq > 12'h380) ? longint'(o.tq) - 896 : 0;
        inc = longint'($signed(o.inc));
        if (inc > 511) inc = 511;
        if (inc < -512) inc = -512;
        lim = inc + 256;
        if (lim < 0) lim = 0;
        if (lim > 511) lim = 511;
        cf = (o.cad > 5'd1) ? longint'(o.cad) + 32 : 0;
        p = o.np ? 0 : tp * longint'(o.sc) * lim * cf;
        if (p >= 134217728) return 12'hFFF;
        return 12'(p >> 15);
    endfunction

    // Reference: value target_curr should take given the current target
    function automatic logic [11:0] next_target(input logic [11:0] res);
`ifdef ASSIST_SEQ_RATE_LIMIT_EN
        if (int'(res) > int'(exp_target) + 256) return 12'(int'(exp_target) + 256);
`endif
        return res;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int v;
        o.tq  = 12'($urandom);
        if ($urandom_range(0, 1) == 1) o.tq = 12'($urandom_range(896, 2400));
        o.cad = 5'($urandom);
        o.np  = ($urandom_range(0, 7) == 0);
        v     = int'($urandom_range(0, 1023)) - 512;
        o.inc = 13'(v);
        if ($urandom_range(0, 3) == 0) o.inc = 13'($urandom);
        o.sc  = 3'($urandom);
        return o;
    endfunction

    task automatic set_ops(input op_t o);
        avg_torque   = o.tq;
        cadence      = o.cad;
        not_pedaling = o.np;
        incline      = o.inc;
        scale        = o.sc;
    endtask

    task automatic launch(input op_t o);
        set_ops(o);
        start = 1'b1;
    endtask

    // Follows one launched computation: checks busy/done timing, capture
    // isolation (inputs scrambled, start re-pulsed) and the written value
    task automatic run_check(input op_t cur, input bit chain, input op_t nxt, input string name);
        logic [11:0] old_t;
        logic [11:0] want;
        old_t = exp_target;
        want  = next_target(model_result(cur));
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++;
            if (i < 5) begin
                if (busy !== 1'b1 || done !== 1'b0 || target_curr !== old_t) begin
                    errors++;
                    $display("FAIL %s busy cycle %0d: busy=%b done=%b tc=%h, want busy=1 done=0 tc=%h",
                             name, i, busy, done, target_curr, old_t);
                end
                set_ops(rand_op());
                start = ($urandom_range(0, 1) == 1);
            end else begin
                if (busy !== 1'b0 || done !== 1'b1 || target_curr !== want) begin
                    errors++;
                    $display("FAIL %s done cycle: busy=%b done=%b tc=%h, want busy=0 done=1 tc=%h",
                             name, busy, done, target_curr, want);
                end
                exp_target = want;
                if (chain) launch(nxt);
                else start = 1'b0;
            end
        end
        if (!chain) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || target_curr !== want) begin
                errors++;
                $display("FAIL %s after done: busy=%b done=%b tc=%h, want busy=0 done=0 tc=%h",
                         name, busy, done, target_curr, want);
            end
        end
    endtask

    function automatic op_t nominal();
        op_t o;
        o.tq = 12'h780; o.cad = 5'd16; o.np = 1'b0; o.inc = 13'h0000; o.sc = 3'd4;
        return o;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        set_ops(op_t'(0));
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || target_curr !== 12'h000) begin
            errors++;
            $display("FAIL reset state: busy=%b done=%b tc=%h, want 0 0 000", busy, done, target_curr);
        end
        exp_target = 12'h000;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        op_t o;
        o = nominal();
        launch(o);
        run_check(o, 1'b0, o, "nominal");
`ifndef ASSIST_SEQ_RATE_LIMIT_EN
        checks++;
        if (target_curr !== 12'h600) begin
            errors++;
            $display("FAIL nominal value: tc=%h want 600", target_curr);
        end
`endif
    endtask

    task automatic test_saturation();
        op_t o;
        o.tq = 12'hFFF; o.cad = 5'd31; o.np = 1'b0; o.inc = 13'h0FFF; o.sc = 3'd7;
        launch(o);
        run_check(o, 1'b0, o, "sat_high");
`ifndef ASSIST_SEQ_RATE_LIMIT_EN
        checks++;
        if (target_curr !== 12'hFFF) begin
            errors++;
            $display("FAIL sat_high value: tc=%h want fff", target_curr);
        end
`endif
        o.inc = 13'h1000;
        launch(o);
        run_check(o, 1'b0, o, "sat_neg_incline");
        checks++;
        if (target_curr !== 12'h000) begin
            errors++;
            $display("FAIL sat_neg_incline value: tc=%h want 000", target_curr);
        end
    endtask

    task automatic test_zero();
        op_t o;
        o = nominal();
        launch(o);
        run_check(o, 1'b0, o, "zero_prep");
        o.cad = 5'd1;
        launch(o);
        run_check(o, 1'b0, o, "cadence_one");
        checks++;
        if (target_curr !== 12'h000) begin
            errors++;
            $display("FAIL cadence_one value: tc=%h want 000", target_curr);
        end
        o = nominal();
        launch(o);
        run_check(o, 1'b0, o, "zero_prep2");
        o.np = 1'b1;
        launch(o);
        run_check(o, 1'b0, o, "not_pedaling");
        checks++;
        if (target_curr !== 12'h000) begin
            errors++;
            $display("FAIL not_pedaling value: tc=%h want 000", target_curr);
        end
    endtask

    task automatic test_back_to_back();
        op_t a, b, c;
        a = rand_op();
        b = rand_op();
        c = nominal();
        launch(a);
        run_check(a, 1'b1, b, "b2b_first");
        run_check(b, 1'b1, c, "b2b_second");
        run_check(c, 1'b0, c, "b2b_third");
    endtask

    task automatic test_random();
        op_t o;
        for (int n = 0; n < 40; n++) begin
            o = rand_op();
            launch(o);
            run_check(o, 1'b0, o, "random");
        end
    endtask

    task automatic test_reset_abort();
        op_t o;
        bit saw_done;
        o = nominal();
        o.tq = 12'h9FF;
        launch(o);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // Now in MUL_AP: reset lands on the next edge
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || target_curr !== 12'h000) begin
            errors++;
            $display("FAIL reset_abort: busy=%b done=%b tc=%h, want 0 0 000", busy, done, target_curr);
        end
        exp_target = 12'h000;
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done || target_curr !== 12'h000) begin
            errors++;
            $display("FAIL reset_abort quiet: activity=%b tc=%h, want 0 000", saw_done, target_curr);
        end
        // Reset and start together: reset wins
        rst = 1'b1;
        launch(nominal());
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_priority: busy=%b done=%b, want 0 0", busy, done);
        end
        // First start after release is accepted
        o = nominal();
        launch(o);
        run_check(o, 1'b0, o, "first_after_reset");
    endtask

`ifdef ASSIST_SEQ_RATE_LIMIT_EN
    task automatic test_rate_limit();
        op_t o;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_target = 12'h000;
        @(negedge clk);
        o = nominal();
        for (int k = 1; k <= 6; k++) begin
            launch(o);
            run_check(o, 1'b0, o, "rate_step");
            checks++;
            if (target_curr !== 12'(k * 256)) begin
                errors++;
                $display("FAIL rate_step %0d: tc=%h want %h", k, target_curr, 12'(k * 256));
            end
        end
        o.cad = 5'd0;
        launch(o);
        run_check(o, 1'b0, o, "rate_drop");
        checks++;
        if (target_curr !== 12'h000) begin
            errors++;
            $display("FAIL rate_drop: tc=%h want 000", target_curr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_saturation();
        test_zero();
        test_back_to_back();
        test_random();
        test_reset_abort();
`ifdef ASSIST_SEQ_RATE_LIMIT_EN
        test_rate_limit();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/assist_seq.md
ASSIST_SEQ -- requirements
Module: assist_seq

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 start  input  1  request one target-current computation; sampled only in IDLE.
REQ-004 avg_torque  input  12  unsigned filtered pedal torque.
REQ-005 cadence  input  5  unsigned pedal cadence.
REQ-006 not_pedaling  input  1  forces result to zero when set.
REQ-007 incline  input  13  signed two's-complement incline.
REQ-008 scale  input  3  unsigned assist level.
REQ-009 busy  output  1  high while a computation is in flight (state != IDLE).
REQ-010 done  output  1  one-cycle pulse; target_curr valid and updated.
REQ-011 target_curr  output  12  registered motor current target; holds between computations.

Function
REQ-012 The block SHALL contain exactly one unsigned 15x15->30 multiplier, time-shared across all products.
REQ-013 States: IDLE, MUL_TQ, MUL_IC, MUL_AP, WR; IDLE->MUL_TQ->MUL_IC->MUL_AP->WR->IDLE, one edge per transition.
REQ-014 The IDLE edge with start=1 SHALL capture all operand inputs into registers; later input changes SHALL NOT affect that computation.
REQ-015 start while busy=1 SHALL be ignored, neither queued nor restarting the sequence.
REQ-016 torque_pos = max(avg_torque - 12'h380, 0), computed from captured operands.
REQ-017 incline_sat: saturate incline to signed 10 bits (+511 / -512); incline_lim = incline_sat + 256, clamped to 0..511.
REQ-018 cadence_factor = (cadence > 1) ? cadence + 32 : 0 (6 bits).
REQ-019 MUL_TQ edge: prod_a(15b) <= torque_pos * scale; MUL_IC edge: prod_b(15b) <= incline_lim * cadence_factor; MUL_AP edge: prod(30b) <= prod_a * prod_b, or 0 if captured not_pedaling=1.
REQ-020 WR edge: result = |prod[29:27] ? 12'hFFF : prod[26:15]; target_curr <= result (subject to REQ-028); done <= 1.
REQ-021 Latency: start sampled at edge E0; done=1 and new target_curr visible in the cycle after E4; busy=1 in the 4 cycles after E0..E4.
REQ-022 done SHALL be high exactly one cycle per computation; busy=0 in that cycle, so start in the done cycle SHALL be accepted.
REQ-023 not_pedaling=1 SHALL NOT shorten latency; result 0 with normal done timing.

Reset
REQ-024 rst=1 at any edge SHALL force state IDLE, busy=0, done=0, target_curr=12'h000, and clear prod_a, prod_b, prod.
REQ-025 rst asserted mid-computation SHALL abort it with no done pulse and no target_curr update.
REQ-026 rst and start both high SHALL give reset priority; start is discarded.
REQ-027 The first start after reset release SHALL be accepted normally.

Configuration
REQ-028 ASSIST_SEQ_RATE_LIMIT_EN defined: at WR, if result > target_curr + 12'h100, target_curr <= target_curr + 12'h100, else target_curr <= result (decreases unlimited, no 12-bit overflow). Undefined: target_curr <= result directly; no limiter logic compiled.

Verification
REQ-029 Nominal: avg_torque=12'h780, scale=4, incline=0, cadence=16, not_pedaling=0, start pulse -> done 4 cycles after E0, target_curr=12'h600 (macro undefined).
REQ-030 Saturation: avg_torque=12'hFFF, scale=7, incline=13'h0FFF, cadence=31 -> target_curr=12'hFFF; incline=13'h1000 -> incline_lim=0, target_curr=12'h000.
REQ-031 Zero cases: cadence=1 -> target_curr=0; not_pedaling=1 with nominal operands -> target_curr=0, done still at E4+1.
REQ-032 Protocol: start re-pulsed during MUL_IC and operands changed after E0 -> single done, result from E0 operands; start in the done cycle -> second done 4 cycles later.
REQ-033 Reset: rst asserted during MUL_AP -> busy=0, done never pulses, target_curr=0 next cycle.
REQ-034 Macro defined: from target_curr=0, nominal operands -> 12'h100, then 12'h200 ... 12'h600 on successive runs; then cadence=0 -> 12'h000 in one run.
